zbus_tracer: RTL and testbench
==============================

ZBUS_TRACER -- requirements
Module: zbus_tracer

Interface
REQ-001 Parameter DEPTH_LOG, default 4, FIFO depth = 2**DEPTH_LOG entries (legal 2..8).
REQ-002 Parameter TS_W, default 16, timestamp field width in bits.
REQ-003 fclk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 zmreq_n, ziorq_n, zrd_n, zwr_n, zm1_n, zrfsh_n  in  1 each  Z80 strobes, already synchronised to fclk.
REQ-006 za  in  16  Z80 address bus; zd  in  8  Z80 data bus.
REQ-007 type_mask  in  6  per-type capture enable, bit n = type code n.
REQ-008 win_en  in  1  address-window filter enable; win_lo, win_hi  in  16 each  inclusive window bounds.
REQ-009 clear  in  1  synchronous FIFO flush request.
REQ-010 pop  in  1  consume head entry.
REQ-011 rd_data  out  27+TS_W  head entry {type[2:0], addr[15:0], data[7:0], ts[TS_W-1:0]}, show-ahead.
REQ-012 empty, full  out  1 each; count  out  DEPTH_LOG+1  entries held.
REQ-013 ovf_cnt  out  8  dropped-entry counter.

Function
REQ-014 Type codes: 0 M1 fetch (mreq,rd,m1 low), 1 mem read, 2 mem write, 3 IO read, 4 IO write, 5 INTA (iorq,m1 low); refresh cycles (zrfsh_n low) never captured.
REQ-015 FSM states IDLE, ACTIVE, COMMIT; IDLE->ACTIVE when any classifiable strobe combination is active in a sampled cycle.
REQ-016 In ACTIVE, type, za and zd latched every clock while the combination persists; last sampled values are the captured ones.
REQ-017 ACTIVE->COMMIT on the first clock the combination deasserts; COMMIT->IDLE unconditionally after one clock.
REQ-018 Push occurs in COMMIT iff type_mask[type]=1 and (win_en=0 or win_lo<=addr<=win_hi, unsigned compare).
REQ-019 win_lo>win_hi with win_en=1: window is empty, all entries filtered.
REQ-020 Latency: entry visible on rd_data/empty=0 one clock after COMMIT.
REQ-021 Pop with empty=1 ignored; pointers and count unchanged.
REQ-022 Push with full=1 and no pop: entry dropped, ovf_cnt incremented, saturating at 255.
REQ-023 Simultaneous push and pop when full: both performed, count stays full, no overflow.
REQ-024 Simultaneous push and pop when empty: push performed, pop ignored, count becomes 1.
REQ-025 Pointers wrap modulo 2**DEPTH_LOG; count uses an extra bit to distinguish full from empty.
REQ-026 clear empties the FIFO and zeroes ovf_cnt; a same-cycle push is discarded; FSM state not affected.
REQ-027 rd_data undefined-but-stable while empty; verification shall not check it then.

Reset
REQ-028 rst has priority over clear and all other inputs.
REQ-029 After reset: FSM IDLE, pointers 0, count 0, empty=1, full=0, ovf_cnt=0, timestamp 0.
REQ-030 Reset asserted mid-cycle (ACTIVE): the cycle in progress is discarded; capture restarts at the next new strobe assertion.

Configuration
REQ-031 Macro ZTRACE_TIMESTAMP_EN defined: free-running TS_W-bit fclk counter (wraps to 0 after all-ones) sampled into ts at COMMIT.
REQ-032 Macro ZTRACE_TIMESTAMP_EN undefined: no counter built, ts field driven constant 0, rd_data width unchanged.

Verification
REQ-033 M1 fetch za=0x0000 zd=0xF3, type_mask=0x3F, win_en=0 -> one entry {0,0x0000,0xF3}, count=1.
REQ-034 IO write za=0x7FFD zd=0x10 with type_mask=0x2F (type 4 off) -> no entry; same with 0x3F -> entry {4,0x7FFD,0x10}.
REQ-035 win_en=1, window 0x4000..0x5AFF, mem writes to 0x3FFF, 0x4000, 0x5AFF, 0x5B00 -> exactly 2 entries, addresses 0x4000 then 0x5AFF.
REQ-036 DEPTH_LOG=4, 20 accepted cycles, no pop -> full=1, count=16, ovf_cnt=4, head = first cycle's entry.
REQ-037 Full FIFO, pop asserted in the push cycle -> count stays 16, ovf_cnt unchanged; then clear -> empty=1, ovf_cnt=0.
REQ-038 With ZTRACE_TIMESTAMP_EN, two fetches 10 fclk apart -> ts difference 10; refresh cycle between them -> not captured.

Source files
------------

// File: rtl/zbus_tracer.sv
// zbus_tracer: classifies Z80 bus cycles, filters them by type and address window,
// and queues {type, addr, data, ts} entries in a show-ahead FIFO with overflow count.
// Optional timestamp counter is built when ZTRACE_TIMESTAMP_EN is defined.
module zbus_tracer #(
    parameter int DEPTH_LOG = 4,
    parameter int TS_W      = 16
) (
    input  logic                    fclk,
    input  logic                    rst,
    input  logic                    zmreq_n,
    input  logic                    ziorq_n,
    input  logic                    zrd_n,
    input  logic                    zwr_n,
    input  logic                    zm1_n,
    input  logic                    zrfsh_n,
    input  logic [15:0]             za,
    input  logic [7:0]              zd,
    input  logic [5:0]              type_mask,
    input  logic                    win_en,
    input  logic [15:0]             win_lo,
    input  logic [15:0]             win_hi,
    input  logic                    clear,
    input  logic                    pop,
    output logic [27+TS_W-1:0]      rd_data,
    output logic                    empty,
    output logic                    full,
    output logic [DEPTH_LOG:0]      count,
    output logic [7:0]              ovf_cnt
);

    localparam int                 DEPTH    = 2**DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] CNT_ONE  = (DEPTH_LOG+1)'(1);
    localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);

    typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

    state_t               state, next_state;
    logic                 cls_vld;
    logic [2:0]           cls_type;
    logic                 cap_en;
    logic                 commit;
    logic                 rst_hold;
    logic [2:0]           cap_type;
    logic [15:0]          cap_addr;
    logic [7:0]           cap_data;
    logic [TS_W-1:0]      ts_cnt;
    logic [27+TS_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic                 pass, push_req, do_push, do_pop, drop;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Decode the strobe combination into a cycle type; refresh is never traced
    always_comb begin
        cls_vld  = 1'b0;
        cls_type = 3'd0;
        if (zrfsh_n) begin
            if (!zmreq_n && !zrd_n && !zm1_n) begin
                cls_vld = 1'b1; cls_type = 3'd0;
            end else if (!zmreq_n && !zrd_n) begin
                cls_vld = 1'b1; cls_type = 3'd1;
            end else if (!zmreq_n && !zwr_n) begin
                cls_vld = 1'b1; cls_type = 3'd2;
            end else if (!ziorq_n && !zrd_n && zm1_n) begin
                cls_vld = 1'b1; cls_type = 3'd3;
            end else if (!ziorq_n && !zwr_n) begin
                cls_vld = 1'b1; cls_type = 3'd4;
            end else if (!ziorq_n && !zm1_n) begin
                cls_vld = 1'b1; cls_type = 3'd5;
            end
        end
    end

    // FSM state register
    always_ff @(posedge fclk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // FSM next state and capture/commit strobes
    always_comb begin
        next_state = state;
        cap_en     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cls_vld && !rst_hold) begin
                    next_state = ACTIVE;
                    cap_en     = 1'b1;
                end
            end
            ACTIVE: begin
                if (cls_vld) cap_en = 1'b1;
                else         next_state = COMMIT;
            end
            COMMIT: begin
                commit     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // After reset, ignore a bus cycle that was already in progress until strobes go idle
    always_ff @(posedge fclk) begin
        if (rst)           rst_hold <= 1'b1;
        else if (!cls_vld) rst_hold <= 1'b0;
    end

    // Capture registers track the bus while the cycle lasts; last sample wins
    always_ff @(posedge fclk) begin
        if (cap_en) begin
            cap_type <= cls_type;
            cap_addr <= za;
            cap_data <= zd;
        end
    end

`ifdef ZTRACE_TIMESTAMP_EN
    // Free-running timestamp, wraps naturally
    always_ff @(posedge fclk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + TS_W'(1);
    end
`else
    assign ts_cnt = '0;
`endif

    assign pass     = type_mask[cap_type] &&
                      (!win_en || ((cap_addr >= win_lo) && (cap_addr <= win_hi)));
    assign push_req = commit && pass && !clear;
    assign do_pop   = pop && !empty && !clear;
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    // FIFO storage; data path carries no reset
    always_ff @(posedge fclk) begin
        if (do_push) mem[wr_ptr] <= {cap_type, cap_addr, cap_data, ts_cnt};
    end

    // FIFO pointers, occupancy and overflow counter
    always_ff @(posedge fclk) begin
        if (rst || clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_cnt <= 8'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (do_pop && !do_push) count <= count - CNT_ONE;
            if (drop) ovf_cnt <= sat_inc8(ovf_cnt);
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);

endmodule

// File: tb/tb_zbus_tracer.sv
// Directed self-checking bench for zbus_tracer (DEPTH_LOG=4, TS_W=16).
module tb_zbus_tracer;

    localparam int DL   = 4;
    localparam int TS_W = 16;

    logic              fclk = 1'b0;
    logic              rst = 1'b1;
    logic              zmreq_n = 1'b1, ziorq_n = 1'b1, zrd_n = 1'b1, zwr_n = 1'b1;
    logic              zm1_n = 1'b1, zrfsh_n = 1'b1;
    logic [15:0]       za = '0;
    logic [7:0]        zd = '0;
    logic [5:0]        type_mask = 6'h3F;
    logic              win_en = 1'b0;
    logic [15:0]       win_lo = '0, win_hi = '0;
    logic              clear = 1'b0, pop = 1'b0;
    logic [27+TS_W-1:0] rd_data;
    logic              empty, full;
    logic [DL:0]       count;
    logic [7:0]        ovf_cnt;

    int checks = 0;
    int failures = 0;
    logic [TS_W-1:0] ts1, ts2;

    zbus_tracer #(.DEPTH_LOG(DL), .TS_W(TS_W)) dut (
        .fclk(fclk), .rst(rst),
        .zmreq_n(zmreq_n), .ziorq_n(ziorq_n), .zrd_n(zrd_n), .zwr_n(zwr_n),
        .zm1_n(zm1_n), .zrfsh_n(zrfsh_n), .za(za), .zd(zd),
        .type_mask(type_mask), .win_en(win_en), .win_lo(win_lo), .win_hi(win_hi),
        .clear(clear), .pop(pop), .rd_data(rd_data), .empty(empty), .full(full),
        .count(count), .ovf_cnt(ovf_cnt)
    );

    always #5 fclk = ~fclk;

    function automatic logic [2:0]  h_type(input logic [27+TS_W-1:0] e); return e[26+TS_W:24+TS_W]; endfunction
    function automatic logic [15:0] h_addr(input logic [27+TS_W-1:0] e); return e[23+TS_W:8+TS_W];  endfunction
    function automatic logic [7:0]  h_data(input logic [27+TS_W-1:0] e); return e[7+TS_W:TS_W];     endfunction
    function automatic logic [TS_W-1:0] h_ts(input logic [27+TS_W-1:0] e); return e[TS_W-1:0];      endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind 0..5 = cycle types, 6 = refresh
    task automatic strobes(input int kind);
        zmreq_n = 1'b1; ziorq_n = 1'b1; zrd_n = 1'b1; zwr_n = 1'b1; zm1_n = 1'b1; zrfsh_n = 1'b1;
        case (kind)
            0: begin zmreq_n = 1'b0; zrd_n = 1'b0; zm1_n = 1'b0; end
            1: begin zmreq_n = 1'b0; zrd_n = 1'b0; end
            2: begin zmreq_n = 1'b0; zwr_n = 1'b0; end
            3: begin ziorq_n = 1'b0; zrd_n = 1'b0; end
            4: begin ziorq_n = 1'b0; zwr_n = 1'b0; end
            5: begin ziorq_n = 1'b0; zm1_n = 1'b0; end
            6: begin zmreq_n = 1'b0; zrfsh_n = 1'b0; end
            default: ;
        endcase
    endtask

    // One bus cycle of 2 clocks, then 3 idle clocks; p/c assert pop/clear during COMMIT.
    // Always consumes exactly 5 rising edges.
    task automatic cyc(input int kind, input logic [15:0] a, input logic [7:0] d,
                       input logic p = 1'b0, input logic c = 1'b0);
        strobes(kind); za = a; zd = d;
        repeat (2) @(posedge fclk);
        #1 strobes(-1);
        @(posedge fclk);
        #1 pop = p; clear = c;
        @(posedge fclk);
        #1 pop = 1'b0; clear = 1'b0;
        @(posedge fclk);
        #1;
    endtask

    task automatic pulse_pop();
        pop = 1'b1; @(posedge fclk); #1 pop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; @(posedge fclk); #1 clear = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge fclk);
        #1 rst = 1'b0;
        @(posedge fclk); #1;
        chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        chk("rst_count", count, 0); chk("rst_ovf", ovf_cnt, 0);

        // M1 fetch
        cyc(0, 16'h0000, 8'hF3);
        chk("m1_count", count, 1); chk("m1_type", h_type(rd_data), 0);
        chk("m1_addr", h_addr(rd_data), 16'h0000); chk("m1_data", h_data(rd_data), 8'hF3);
        pulse_pop();
        chk("m1_pop_empty", empty, 1);

        // Type mask
        type_mask = 6'h2F;
        cyc(4, 16'h7FFD, 8'h10);
        chk("mask_off_empty", empty, 1);
        type_mask = 6'h3F;
        cyc(4, 16'h7FFD, 8'h10);
        chk("mask_on_count", count, 1); chk("iow_type", h_type(rd_data), 4);
        chk("iow_addr", h_addr(rd_data), 16'h7FFD); chk("iow_data", h_data(rd_data), 8'h10);
        pulse_pop();

        // Address window
        win_en = 1'b1; win_lo = 16'h4000; win_hi = 16'h5AFF;
        cyc(2, 16'h3FFF, 8'h01); cyc(2, 16'h4000, 8'h02);
        cyc(2, 16'h5AFF, 8'h03); cyc(2, 16'h5B00, 8'h04);
        chk("win_count", count, 2); chk("win_head0", h_addr(rd_data), 16'h4000);
        pulse_pop();
        chk("win_head1", h_addr(rd_data), 16'h5AFF);
        pulse_pop();
        chk("win_drain", empty, 1);
        win_lo = 16'h5000; win_hi = 16'h4000;
        cyc(2, 16'h4800, 8'h05); cyc(2, 16'h5000, 8'h06);
        chk("win_inverted", empty, 1);
        win_en = 1'b0;

        // Refresh ignored; other types
        cyc(6, 16'h0011, 8'h00);
        chk("rfsh_ignored", empty, 1);
        cyc(1, 16'h1234, 8'h56); cyc(3, 16'h00FE, 8'hBF); cyc(5, 16'h0038, 8'hFF);
        chk("types_count", count, 3); chk("memrd_type", h_type(rd_data), 1);
        pulse_pop(); chk("iord_type", h_type(rd_data), 3); chk("iord_addr", h_addr(rd_data), 16'h00FE);
        pulse_pop(); chk("inta_type", h_type(rd_data), 5);
        pulse_pop();

        // Timestamps: two fetch commits 10 clocks apart, refresh between
        cyc(0, 16'h0100, 8'hAA); cyc(6, 16'h0005, 8'h00); cyc(0, 16'h0101, 8'hBB);
        chk("ts_count", count, 2);
        ts1 = h_ts(rd_data); pulse_pop();
        chk("ts_second_addr", h_addr(rd_data), 16'h0101);
        ts2 = h_ts(rd_data); pulse_pop();
`ifdef ZTRACE_TIMESTAMP_EN
        chk("ts_diff", ts2 - ts1, 10);
`else
        chk("ts_zero1", ts1, 0); chk("ts_zero2", ts2, 0);
`endif

        // Fill to overflow
        for (int i = 0; i < 20; i++) cyc(1, 16'(i), 8'(i));
        chk("fill_full", full, 1); chk("fill_count", count, 16); chk("fill_ovf", ovf_cnt, 4);
        chk("fill_head_addr", h_addr(rd_data), 16'h0000); chk("fill_head_data", h_data(rd_data), 8'h00);

        // Push and pop together while full
        cyc(1, 16'h0099, 8'h99, 1'b1, 1'b0);
        chk("fullpp_count", count, 16); chk("fullpp_ovf", ovf_cnt, 4);
        chk("fullpp_head", h_addr(rd_data), 16'h0001);

        // Overflow saturation
        for (int i = 0; i < 253; i++) cyc(2, 16'h2000, 8'h00);
        chk("ovf_sat", ovf_cnt, 255);

        pulse_clear();
        chk("clr_empty", empty, 1); chk("clr_ovf", ovf_cnt, 0); chk("clr_count", count, 0);

        // Pop on empty ignored
        pulse_pop();
        chk("pop_empty_count", count, 0);
        cyc(2, 16'hBEEF, 8'h42);
        chk("after_pe_count", count, 1); chk("after_pe_addr", h_addr(rd_data), 16'hBEEF);
        pulse_pop();

        // Push and pop together while empty
        cyc(2, 16'hCAFE, 8'h24, 1'b1, 1'b0);
        chk("emptypp_count", count, 1); chk("emptypp_addr", h_addr(rd_data), 16'hCAFE);
        pulse_pop();

        // Clear discards same-cycle push
        cyc(2, 16'h1111, 8'h11, 1'b0, 1'b1);
        chk("clr_push_empty", empty, 1);

        // Reset in the middle of an active cycle
        strobes(1); za = 16'h7777; zd = 8'h77;
        @(posedge fclk);
        #1 rst = 1'b1;
        @(posedge fclk);
        #1 rst = 1'b0;
        repeat (2) @(posedge fclk);
        #1 strobes(-1);
        repeat (4) @(posedge fclk);
        #1;
        chk("midrst_empty", empty, 1); chk("midrst_ovf", ovf_cnt, 0);
        cyc(2, 16'hAAAA, 8'h55);
        chk("postrst_count", count, 1); chk("postrst_addr", h_addr(rd_data), 16'hAAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
